muldiv_sequencer: RTL

Multi-cycle multiply/divide sequencer sitting beside the Execute stage ALU. It accepts MULT/MULTU/DIV/DIVU operands from Execute and iterates one bit per cycle over 32 cycles. It owns the architectural HI/LO registers and produces the stall request that freezes the pipeline while a result is pending.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 54 +++++
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer: operation encodings
// as presented by Execute, sequencer state encoding, the step datapath mode,
// the iteration count, and small helpers that decode an operation.
package muldiv_pkg;

    // One iteration per operand bit.
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    // MULT and DIV are the signed forms (low opcode bit clear).
    function automatic logic op_signed(input op_e op);
        return ~op[0];
    endfunction

    // The high opcode bit selects divide.
    function automatic mode_e op_mode(input op_e op);
        return mode_e'(op[1]);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration of the sequencer datapath, shared by both
// operations. The accumulator {acc_hi, acc_lo} is processed MSB-first; the
// next bit of the (magnitude) multiplier / dividend arrives on bit_in.
//   mode     in   MODE_MUL: shift-add, MODE_DIV: restoring shift-subtract
//   acc_hi   in   accumulator high half (product high / partial remainder)
//   acc_lo   in   accumulator low half (product low / quotient so far)
//   operand  in   multiplicand magnitude / divisor magnitude
//   bit_in   in   current MSB of the multiplier / dividend magnitude
//   next_hi  out  accumulator high half after this step
//   next_lo  out  accumulator low half after this step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  acc_hi,
    input  logic [WIDTH-1:0]  acc_lo,
    input  logic [WIDTH-1:0]  operand,
    input  logic              bit_in,
    output logic [WIDTH-1:0]  next_hi,
    output logic [WIDTH-1:0]  next_lo
);

    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic               fits;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the if/else leaves it unassigned (which would infer a latch).
        shifted = {acc_hi, acc_lo} << 1;
        addend  = bit_in ? {{WIDTH{1'b0}}, operand} : '0;
        sum     = shifted + addend;
        partial = {acc_hi, bit_in};
        diff    = partial - {1'b0, operand};
        // An explicit compare rather than the borrow bit: with a zero divisor
        // the partial remainder can exceed WIDTH bits of headroom, and we still
        // want every quotient bit set so LO ends as all ones.
        fits    = (partial >= {1'b0, operand});
        next_hi = sum[2*WIDTH-1:WIDTH];
        next_lo = sum[WIDTH-1:0];

        if (mode == MODE_DIV) begin
            next_hi = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU unit beside the Execute ALU. Operates on
// magnitudes for one bit per cycle, then applies sign correction and writes
// the architectural HI/LO registers. Requests a pipeline stall while a
// result is pending and Execute either reads HI/LO or issues a new op.
//   Clk       in   rising-edge clock
//   Reset     in   synchronous, active-high
//   Start     in   launch request (ignored while Busy)
//   Op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A         in   multiplicand / dividend
//   B         in   multiplier / divisor
//   ReadHiLo  in   Execute holds MFHI/MFLO this cycle
//   Busy      out  operation in flight
//   Done      out  one-cycle pulse, HI/LO just updated
//   Stall     out  freeze IF/ID/EX (combinational)
//   HI        out  product high / remainder
//   LO        out  product low / quotient
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              ReadHiLo,
    output logic              Busy,
    output logic              Done,
    output logic              Stall,
    output logic [WIDTH-1:0]  HI,
    output logic [WIDTH-1:0]  LO
);

    localparam int CW = $clog2(ITER) + 1;

    state_e             state;
    state_e             state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   src;       // |A|, shifted left one bit per step
    logic [WIDTH-1:0]   operand;   // |B|
    op_e                op_r;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated

    logic               last_step;
    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign last_step = (count == CW'(ITER - 1));
    assign in_signed = op_signed(op_e'(Op));
    assign a_neg     = in_signed & A[WIDTH-1];
    assign b_neg     = in_signed & B[WIDTH-1];
    // 32'h80000000 maps to itself, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    assign Busy  = (state != S_IDLE);
    assign Stall = Busy & (ReadHiLo | Start);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode    (op_mode(op_r)),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .bit_in  (src[WIDTH-1]),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign correction applied in FIX.
    always_comb begin
        product     = {acc_hi, acc_lo};
        product_fix = neg_res ? -product : product;
        // Divide by zero keeps the raw all-ones quotient regardless of signs.
        quo_fix     = (neg_res && (operand != '0)) ? -acc_lo : acc_lo;
        rem_fix     = neg_rem ? -acc_hi : acc_hi;
        fix_hi      = product_fix[2*WIDTH-1:WIDTH];
        fix_lo      = product_fix[WIDTH-1:0];
        if (op_mode(op_r) == MODE_DIV) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its inputs from before the edge, independent of block order.
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start) state_next = S_CALC;
            S_CALC:  if (last_step) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and architectural registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            src     <= '0;
            operand <= '0;
            op_r    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op_r    <= op_e'(Op);
                        src     <= a_mag;
                        operand <= b_mag;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        acc_hi  <= '0;
                        acc_lo  <= '0;
                        count   <= '0;
                    end
                end
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    src    <= src << 1;
                    count  <= count + CW'(1);
                end
                S_FIX: begin
                    HI   <= fix_hi;
                    LO   <= fix_lo;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
